// File: rtl/fft_sample_feeder.sv
// fft_sample_feeder: Wishbone slave that buffers firmware-written samples in a
// FIFO and streams them to the FFT core with a frame-last marker.
module fft_sample_feeder #(
  parameter logic [31:0] BASE_ADDR = 32'h1002_0000,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned N_POINTS  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        smp_valid_o,
  output logic [31:0] smp_data_o,
  output logic        smp_last_o,
  input  logic        smp_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(N_POINTS);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [FW-1:0] IDX_LAST = FW'(N_POINTS - 1);
  localparam logic [FW-1:0] IDX_ONE  = FW'(1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_ovf;
  logic [15:0]   r_frames;
  logic [FW-1:0] r_fidx;
  logic          r_ack;
  logic [31:0]   r_dat;

  logic          w_req;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_ovf_clr;
  logic          w_full;
  logic          w_empty;
  logic          w_last;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused_bits;

  assign w_req      = cyc_i & stb_i & ~r_ack & (adr_i[31:12] == BASE_ADDR[31:12]);
  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_last     = ~w_empty & (r_fidx == IDX_LAST);
  assign w_push_req = w_req & we_i & (adr_i[3:2] == 2'b00);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO
  // is always dropped.
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = ~w_empty & smp_ready_i;
  assign w_flush    = w_req & we_i & (adr_i[3:2] == 2'b10) & dat_i[0];
  assign w_ovf_clr  = w_req & we_i & (adr_i[3:2] == 2'b10) & dat_i[1];

  assign w_status      = {13'd0, r_ovf, w_full, w_empty, {(15-AW){1'b0}}, r_level};
  assign w_unused_bits = ^{adr_i[11:4], adr_i[1:0]};

  // Register read mux; only the read-only registers return data.
  always_comb begin
    w_rdata = '0;
    case (adr_i[3:2])
      2'b01:   w_rdata = w_status;
      2'b11:   w_rdata = {16'd0, r_frames};
      default: w_rdata = '0;
    endcase
  end

  // Bus acknowledge and registered read data, one-cycle pulse per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req & ~we_i) ? w_rdata : '0;
    end
  end

  // Sample storage; contents need no reset since level gates the output.
  always_ff @(posedge clk) begin
    if (w_push & ~rst) begin
      r_mem[r_wr_ptr] <= dat_i;
    end
  end

  // FIFO pointers and fill level; flush overrides a same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow flag, cleared by firmware through CTRL bit 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_push_req & w_full) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Frame position and completed-frame counter; a flushed pop counts nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fidx   <= '0;
      r_frames <= '0;
    end else if (w_flush) begin
      r_fidx <= '0;
    end else if (w_pop) begin
      r_fidx <= (r_fidx == IDX_LAST) ? '0 : r_fidx + IDX_ONE;
      if (r_fidx == IDX_LAST) r_frames <= r_frames + 16'd1;
    end
  end

  assign ack_o       = r_ack;
  assign dat_o       = r_dat;
  assign smp_valid_o = ~w_empty;
  assign smp_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign smp_last_o  = w_last;

endmodule

// File: tb/tb_fft_sample_feeder.sv
// Scoreboard bench for fft_sample_feeder: stimulus drives Wishbone and ready,
// a negedge model/monitor predicts stream and register responses.
module tb_fft_sample_feeder;

  localparam logic [31:0] BASE  = 32'h1002_0000;
  localparam int          DEPTH = 64;
  localparam int          NPTS  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] rdat, sdata;
  logic        ack, valid, last;
  logic        ready = 1'b0;
  int          ready_mode = 0;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] val;
  } rsp_t;

  logic [31:0] exp_q[$];
  rsp_t        rsp_q[$];
  int          m_fidx = 0;
  int          m_frames = 0;
  bit          m_ovf = 0;
  bit          m_ack = 0;
  bit          chk_rst = 0;

  fft_sample_feeder #(
    .BASE_ADDR(BASE),
    .DEPTH(DEPTH),
    .N_POINTS(NPTS)
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .dat_o(rdat), .ack_o(ack),
    .smp_valid_o(valid), .smp_data_o(sdata), .smp_last_o(last),
    .smp_ready_i(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor and reference model: check the current cycle, then predict the
  // effect of the upcoming edge from the bench-driven inputs.
  always @(negedge clk) begin
    bit          req, pop, full, flush, do_push;
    logic [31:0] v;
    rsp_t        r;
    if (rst) begin
      exp_q.delete();
      rsp_q.delete();
      m_fidx = 0; m_frames = 0; m_ovf = 0; m_ack = 0;
      chk_rst = 1;
    end else begin
      chk("valid", 32'(valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("data", sdata, exp_q[0]);
        chk("last", 32'(last), 32'(m_fidx == NPTS-1));
      end else begin
        chk("last_idle", 32'(last), 32'd0);
      end
      chk("ack", 32'(ack), 32'(m_ack));
      if (m_ack && ack) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_queue", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          if (r.is_rd) chk("rdata", rdat, r.val);
        end
      end
      if (chk_rst) begin
        chk("rst_dat_o", rdat, 32'd0);
        chk("rst_smp_data", sdata, 32'd0);
        chk_rst = 0;
      end

      req     = cyc && stb && !m_ack && (adr[31:12] == BASE[31:12]);
      pop     = (exp_q.size() != 0) && ready;
      full    = (exp_q.size() == DEPTH);
      flush   = 0;
      do_push = 0;
      if (req) begin
        if (!we) begin
          case (adr[3:2])
            2'd1: v = 32'(exp_q.size()) | (32'(exp_q.size() == 0) << 16)
                      | (32'(full) << 17) | (32'(m_ovf) << 18);
            2'd3: v = 32'(m_frames);
            default: v = 32'd0;
          endcase
          rsp_q.push_back('{1'b1, v});
        end else begin
          rsp_q.push_back('{1'b0, 32'd0});
          if (adr[3:2] == 2'd0) begin
            if (full) m_ovf = 1;
            else do_push = 1;
          end
          if (adr[3:2] == 2'd2) begin
            if (wdat[0]) flush = 1;
            if (wdat[1]) m_ovf = 0;
          end
        end
      end
      if (flush) begin
        exp_q.delete();
        m_fidx = 0;
      end else if (pop) begin
        void'(exp_q.pop_front());
        if (m_fidx == NPTS-1) m_frames = (m_frames + 1) % 65536;
        m_fidx = (m_fidx + 1) % NPTS;
      end
      if (do_push) exp_q.push_back(wdat);
      m_ack = req;
    end
  end

  // Ready driver: 0 = hold low, 1 = hold high, 2 = random (mostly high).
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        default: ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  function automatic logic [31:0] reg_addr(input int r);
    return BASE | (32'($urandom_range(0, 255)) << 4) | (32'(r) << 2);
  endfunction

  // One Wishbone access with strobe held across the ack cycle.
  task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    repeat (2) begin @(posedge clk); #1; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) wb(1'b1, reg_addr(0), $urandom);
  endtask

  initial begin
    idle(3);
    #0 rst = 1'b0;
    idle(1);

    // Reset status, register reads and an out-of-window access
    wb(1'b0, reg_addr(1), 32'd0);
    wb(1'b0, reg_addr(0), 32'd0);
    wb(1'b0, reg_addr(2), 32'd0);
    wb(1'b0, reg_addr(3), 32'd0);
    wb(1'b1, 32'h1003_0000, 32'h1234_5678);
    idle(3);

    // One full frame with ready held high
    ready_mode = 1;
    push_n(64);
    idle(5);
    wb(1'b0, reg_addr(3), 32'd0);

    // Overflow with ready low, clear, read-only write ignored, drain
    do_reset();
    ready_mode = 0;
    idle(2);
    push_n(65);
    wb(1'b0, reg_addr(1), 32'd0);
    wb(1'b1, reg_addr(2), 32'h2);
    wb(1'b0, reg_addr(1), 32'd0);
    wb(1'b1, reg_addr(1), 32'hffff_ffff);
    wb(1'b1, reg_addr(3), 32'hffff_ffff);
    wb(1'b0, reg_addr(1), 32'd0);
    ready_mode = 1;
    idle(80);
    wb(1'b0, reg_addr(3), 32'd0);
    wb(1'b0, reg_addr(1), 32'd0);

    // Partial frame flushed, then a clean frame
    do_reset();
    ready_mode = 0;
    idle(2);
    push_n(10);
    wb(1'b1, reg_addr(2), 32'h1);
    ready_mode = 1;
    push_n(64);
    idle(5);
    wb(1'b0, reg_addr(3), 32'd0);

    // Flush racing a pop: ready high with data queued
    ready_mode = 0;
    idle(2);
    push_n(5);
    ready_mode = 1;
    idle(2);
    wb(1'b1, reg_addr(2), 32'h1);
    idle(3);
    wb(1'b0, reg_addr(3), 32'd0);

    // Three frames with random backpressure
    do_reset();
    ready_mode = 2;
    push_n(192);
    ready_mode = 1;
    idle(80);
    wb(1'b0, reg_addr(3), 32'd0);

    // Reset mid-frame after about 20 pops, then a fresh frame
    do_reset();
    ready_mode = 0;
    idle(2);
    push_n(30);
    ready_mode = 1;
    idle(20);
    do_reset();
    push_n(64);
    idle(5);
    wb(1'b0, reg_addr(3), 32'd0);
    wb(1'b0, reg_addr(1), 32'd0);
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
